aval_hd_collector: RTL and testbench
====================================

Name: aval_hd_collector

Overview:
- Downstream consumer of the Fibonacci transform stage in the avalanche-effect flow.
- Captures each finished 16-bit transform output (out_B, qualified by done_trans).
- Pairs consecutive captures and computes the Hamming distance between the two words with a bit-serial popcount.
- Accumulates distances over a programmed number of pairs and flags completion, giving the bench/top level a hardware avalanche metric.

Parameters:
- DATA_W, 16, width of captured transform output.
- NUM_PAIRS, 8, pairs to measure before done asserts; range 1..65535.
- SUM_W, 16, width of the saturating distance accumulator.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart of a measurement run; same effect as rst.
- done_trans  in  1  transform-complete level from upstream; may stay high for many cycles.
- out_B  in  DATA_W  transform result; valid while done_trans is high.
- hd_last  out  5  Hamming distance of the most recent pair (0..16).
- hd_valid  out  1  one-cycle pulse when hd_last/hd_sum update.
- hd_sum  out  SUM_W  saturating sum of all pair distances in this run.
- pair_cnt  out  16  pairs completed in this run.
- busy  out  1  high in COUNT state.
- done  out  1  level; high once pair_cnt == NUM_PAIRS, until rst/clear.
- overrun  out  1  sticky; a capture edge arrived while the word could not be accepted.

Behaviour:
- Reset
  - rst or clear high at a clock edge forces all outputs and registers to 0 and state to WAIT_A.
  - This includes the edge-detect history register, the captured words and the popcount counter.
  - rst has priority; clear is identical in effect.
  - Reset mid-COUNT abandons the pair; no hd_valid is issued.
- Edge detect
  - cap = done_trans & ~done_trans_q, where done_trans_q is done_trans registered.
  - A level held high produces exactly one capture.
- States
  - WAIT_A: on cap, latch out_B into word_a, go to WAIT_B.
  - WAIT_B: on cap, latch out_B into word_b, load diff = word_a ^ out_B, clear bit counter, go to COUNT.
  - COUNT: each cycle shift diff right by 1 and add its LSB to the running count. After exactly DATA_W cycles, go to UPDATE.
  - UPDATE (one cycle): register the following, then go to WAIT_A, or to DONE if the new pair_cnt == NUM_PAIRS.
    - hd_last <= count
    - hd_sum <= sat(hd_sum + count)
    - pair_cnt <= pair_cnt + 1
    - hd_valid <= 1
  - DONE: done = 1; further caps are ignored and do not set overrun; leave only via rst/clear.
- Timing
  - Second word latched at edge N.
  - COUNT occupies edges N+1..N+16; UPDATE is at edge N+17.
  - hd_valid is high for the cycle after edge N+17.
  - Pair latency is 17 cycles from the capture of the second word.
- Pairing and overrun
  - Pairs are non-overlapping: word 1/2, word 3/4, and so on.
  - A cap during COUNT or UPDATE is dropped and sets overrun = 1 (sticky until rst/clear).
  - The state machine is unaffected by a dropped cap.
- Arithmetic
  - The popcount counter is 5 bits.
  - The hd_sum add is done at SUM_W+1 bits. If the result exceeds 2^SUM_W-1, hd_sum holds all-ones and stays there.
  - pair_cnt never wraps, since the DONE state stops it at NUM_PAIRS.
- Simultaneous cap and clear: clear wins; the word is discarded.

Optional Feature:
- Macro: AVAL_MINMAX_EN.
- Defined:
  - Adds outputs hd_min[4:0] and hd_max[4:0].
  - Reset values: hd_min = 31, hd_max = 0.
  - Both update in UPDATE alongside hd_last: hd_min takes the smaller of itself and count, hd_max the larger.
- Undefined:
  - Ports and registers are absent.
  - All other behaviour is identical.

Test Plan:
- Basic pair: after rst, present 0x00A2 then 0x0091, each as a 3-cycle done_trans pulse → hd_last = 4, hd_valid pulses once 17 cycles after the second capture, hd_sum = 4, pair_cnt = 1.
- Extremes: pair 0x0000/0xFFFF → hd_last = 16; pair 0x1234/0x1234 → hd_last = 0; hd_sum accumulates to 16.
- Run completion: NUM_PAIRS = 2, two pairs of 0x00A2/0x0091.
  - Expect done = 1 with pair_cnt = 2 and hd_sum = 8.
  - A fifth capture is ignored, and overrun stays 0.
- Overrun: assert a cap 5 cycles after the second word of a pair.
  - Expect overrun = 1 and that word dropped.
  - The next two caps form the next pair.
- Saturation: override SUM_W = 5, two 0x0000/0xFFFF pairs → hd_sum = 16, then 31 (saturated, not 0).
- Reset mid-operation:
  - Assert rst at COUNT cycle 8 → every output is 0 next cycle, and no hd_valid is issued.
  - A following 0x00A2/0x0091 pair yields hd_last = 4.
  - With AVAL_MINMAX_EN, after pairs with distances 4 and 16: hd_min = 4, hd_max = 16.

Source files
------------

// File: rtl/aval_hd_collector_if.sv
// rtl/aval_hd_collector_if.sv - transform-capture inputs and Hamming-distance results
// hd_min/hd_max exist only when AVAL_MINMAX_EN is defined.
interface aval_hd_collector_if #(
  parameter int DATA_W = 16,
  parameter int SUM_W  = 16
);
  logic              done_trans;
  logic [DATA_W-1:0] out_B;
  logic [4:0]        hd_last;
  logic              hd_valid;
  logic [SUM_W-1:0]  hd_sum;
  logic [15:0]       pair_cnt;
  logic              busy;
  logic              done;
  logic              overrun;
`ifdef AVAL_MINMAX_EN
  logic [4:0]        hd_min;
  logic [4:0]        hd_max;
`endif

  modport master (
`ifdef AVAL_MINMAX_EN
    input  hd_min, hd_max,
`endif
    output done_trans, out_B,
    input  hd_last, hd_valid, hd_sum, pair_cnt, busy, done, overrun
  );

  modport slave (
`ifdef AVAL_MINMAX_EN
    output hd_min, hd_max,
`endif
    input  done_trans, out_B,
    output hd_last, hd_valid, hd_sum, pair_cnt, busy, done, overrun
  );
endinterface

// File: rtl/aval_hd_collector.sv
// rtl/aval_hd_collector.sv - pairs transform outputs and accumulates their Hamming distances
// Optional hd_min/hd_max tracking is enabled by defining AVAL_MINMAX_EN.
module aval_hd_collector #(
  parameter int DATA_W    = 16,
  parameter int NUM_PAIRS = 8,
  parameter int SUM_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  aval_hd_collector_if.slave bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_WAIT_A = 3'd0,
    S_WAIT_B = 3'd1,
    S_COUNT  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              sync_rst;
  logic              done_trans_q;
  logic              cap;
  logic              last_pair;
  logic [DATA_W-1:0] word_a_q, word_a_d;
  logic [DATA_W-1:0] diff_q, diff_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]        count_q, count_d;
  logic [4:0]        hd_last_q, hd_last_d;
  logic              hd_valid_q, hd_valid_d;
  logic [SUM_W-1:0]  hd_sum_q, hd_sum_d;
  logic [SUM_W:0]    sum_ext;
  logic [15:0]       pair_cnt_q, pair_cnt_d;
  logic              overrun_q, overrun_d;
`ifdef AVAL_MINMAX_EN
  logic [4:0]        hd_min_q, hd_min_d;
  logic [4:0]        hd_max_q, hd_max_d;
`endif

  assign sync_rst  = rst | clear;
  assign cap       = bus.done_trans & ~done_trans_q;
  assign last_pair = (pair_cnt_q + 16'd1) == 16'(NUM_PAIRS);
  assign sum_ext   = {1'b0, hd_sum_q} + (SUM_W+1)'(count_q);

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= S_WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_A: if (cap) state_d = S_WAIT_B;
      S_WAIT_B: if (cap) state_d = S_COUNT;
      S_COUNT:  if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = S_UPDATE;
      S_UPDATE: state_d = last_pair ? S_DONE : S_WAIT_A;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_WAIT_A;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_COUNT);
    bus.done = (state_q == S_DONE);
  end

  // The second word of a pair is only ever needed as word_a ^ word_b, so it lives in diff.
  always_comb begin
    word_a_d   = word_a_q;
    diff_d     = diff_q;
    bit_cnt_d  = bit_cnt_q;
    count_d    = count_q;
    hd_last_d  = hd_last_q;
    hd_sum_d   = hd_sum_q;
    pair_cnt_d = pair_cnt_q;
    overrun_d  = overrun_q;
    hd_valid_d = 1'b0;
`ifdef AVAL_MINMAX_EN
    hd_min_d   = hd_min_q;
    hd_max_d   = hd_max_q;
`endif
    case (state_q)
      S_WAIT_A: begin
        if (cap) word_a_d = bus.out_B;
      end
      S_WAIT_B: begin
        if (cap) begin
          diff_d    = word_a_q ^ bus.out_B;
          bit_cnt_d = '0;
          count_d   = '0;
        end
      end
      S_COUNT: begin
        count_d   = count_q + 5'(diff_q[0]);
        diff_d    = diff_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (cap) overrun_d = 1'b1;
      end
      S_UPDATE: begin
        hd_last_d  = count_q;
        hd_sum_d   = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        pair_cnt_d = pair_cnt_q + 16'd1;
        hd_valid_d = 1'b1;
        if (cap) overrun_d = 1'b1;
`ifdef AVAL_MINMAX_EN
        hd_min_d   = (count_q < hd_min_q) ? count_q : hd_min_q;
        hd_max_d   = (count_q > hd_max_q) ? count_q : hd_max_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      done_trans_q <= 1'b0;
      word_a_q     <= '0;
      diff_q       <= '0;
      bit_cnt_q    <= '0;
      count_q      <= '0;
      hd_last_q    <= '0;
      hd_valid_q   <= 1'b0;
      hd_sum_q     <= '0;
      pair_cnt_q   <= '0;
      overrun_q    <= 1'b0;
`ifdef AVAL_MINMAX_EN
      hd_min_q     <= 5'd31;
      hd_max_q     <= 5'd0;
`endif
    end else begin
      done_trans_q <= bus.done_trans;
      word_a_q     <= word_a_d;
      diff_q       <= diff_d;
      bit_cnt_q    <= bit_cnt_d;
      count_q      <= count_d;
      hd_last_q    <= hd_last_d;
      hd_valid_q   <= hd_valid_d;
      hd_sum_q     <= hd_sum_d;
      pair_cnt_q   <= pair_cnt_d;
      overrun_q    <= overrun_d;
`ifdef AVAL_MINMAX_EN
      hd_min_q     <= hd_min_d;
      hd_max_q     <= hd_max_d;
`endif
    end
  end

  assign bus.hd_last  = hd_last_q;
  assign bus.hd_valid = hd_valid_q;
  assign bus.hd_sum   = hd_sum_q;
  assign bus.pair_cnt = pair_cnt_q;
  assign bus.overrun  = overrun_q;
`ifdef AVAL_MINMAX_EN
  assign bus.hd_min   = hd_min_q;
  assign bus.hd_max   = hd_max_q;
`endif
endmodule

// File: tb/tb_aval_hd_collector.sv
// tb/tb_aval_hd_collector.sv - directed self-checking bench for aval_hd_collector
// Three instances: default, NUM_PAIRS=2 and SUM_W=5; AVAL_MINMAX_EN adds min/max checks.
module tb_aval_hd_collector;
  logic clk = 1'b0;
  logic rst;
  logic clear;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  aval_hd_collector_if #(.DATA_W(16), .SUM_W(16)) if_a ();
  aval_hd_collector_if #(.DATA_W(16), .SUM_W(16)) if_b ();
  aval_hd_collector_if #(.DATA_W(16), .SUM_W(5))  if_c ();

  aval_hd_collector #(.DATA_W(16), .NUM_PAIRS(8), .SUM_W(16)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_a)
  );
  aval_hd_collector #(.DATA_W(16), .NUM_PAIRS(2), .SUM_W(16)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_b)
  );
  aval_hd_collector #(.DATA_W(16), .NUM_PAIRS(8), .SUM_W(5)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int k, input logic dt, input logic [15:0] w);
    case (k)
      0: begin if_a.done_trans = dt; if_a.out_B = w; end
      1: begin if_b.done_trans = dt; if_b.out_B = w; end
      default: begin if_c.done_trans = dt; if_c.out_B = w; end
    endcase
  endtask

  // Raise done_trans for 'hold' cycles, then leave one idle cycle.
  task automatic send(input int k, input logic [15:0] w, input int hold);
    drive(k, 1'b1, w);
    cyc(hold);
    drive(k, 1'b0, 16'h0);
    cyc(1);
  endtask

  function automatic logic valid_of(input int k);
    case (k)
      0:       return if_a.hd_valid;
      1:       return if_b.hd_valid;
      default: return if_c.hd_valid;
    endcase
  endfunction

  task automatic wait_valid(input int k, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = valid_of(k);
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic seen;
    rst   = 1'b1;
    clear = 1'b0;
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    drive(2, 1'b0, 16'h0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    check("rst_hd_last",  32'(if_a.hd_last),  32'd0);
    check("rst_hd_valid", 32'(if_a.hd_valid), 32'd0);
    check("rst_hd_sum",   32'(if_a.hd_sum),   32'd0);
    check("rst_pair_cnt", 32'(if_a.pair_cnt), 32'd0);
    check("rst_busy",     32'(if_a.busy),     32'd0);
    check("rst_done",     32'(if_a.done),     32'd0);
    check("rst_overrun",  32'(if_a.overrun),  32'd0);
`ifdef AVAL_MINMAX_EN
    check("rst_hd_min",   32'(if_a.hd_min),   32'd31);
    check("rst_hd_max",   32'(if_a.hd_max),   32'd0);
`endif

    // Run completion with NUM_PAIRS = 2
    send(1, 16'h00A2, 3);
    send(1, 16'h0091, 3);
    wait_valid(1, "b_pair1_valid");
    check("b_pair1_done",     32'(if_b.done),     32'd0);
    check("b_pair1_pair_cnt", 32'(if_b.pair_cnt), 32'd1);
    send(1, 16'h00A2, 3);
    send(1, 16'h0091, 3);
    wait_valid(1, "b_pair2_valid");
    check("b_done",     32'(if_b.done),     32'd1);
    check("b_pair_cnt", 32'(if_b.pair_cnt), 32'd2);
    check("b_hd_sum",   32'(if_b.hd_sum),   32'd8);
    send(1, 16'h1234, 3);
    cyc(20);
    check("b_ignored_pair_cnt", 32'(if_b.pair_cnt), 32'd2);
    check("b_ignored_done",     32'(if_b.done),     32'd1);
    check("b_ignored_overrun",  32'(if_b.overrun),  32'd0);
    check("b_ignored_busy",     32'(if_b.busy),     32'd0);

    // Saturation with SUM_W = 5
    send(2, 16'h0000, 3);
    send(2, 16'hFFFF, 3);
    wait_valid(2, "c_pair1_valid");
    check("c_pair1_hd_last", 32'(if_c.hd_last), 32'd16);
    check("c_pair1_hd_sum",  32'(if_c.hd_sum),  32'd16);
    send(2, 16'h0000, 3);
    send(2, 16'hFFFF, 3);
    wait_valid(2, "c_pair2_valid");
    check("c_sat_hd_sum",    32'(if_c.hd_sum),  32'd31);

    // Basic pair with exact timing: second capture at edge N, send returns after N+3
    send(0, 16'h00A2, 3);
    send(0, 16'h0091, 3);
    cyc(12);
    check("basic_busy_n15",   32'(if_a.busy),     32'd1);
    cyc(1);
    check("basic_valid_n16",  32'(if_a.hd_valid), 32'd0);
    check("basic_busy_n16",   32'(if_a.busy),     32'd0);
    cyc(1);
    check("basic_valid_n17",  32'(if_a.hd_valid), 32'd1);
    check("basic_hd_last",    32'(if_a.hd_last),  32'd4);
    check("basic_hd_sum",     32'(if_a.hd_sum),   32'd4);
    check("basic_pair_cnt",   32'(if_a.pair_cnt), 32'd1);
    cyc(1);
    check("basic_valid_pulse", 32'(if_a.hd_valid), 32'd0);

    // Clear restarts the run
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_hd_sum",   32'(if_a.hd_sum),   32'd0);
    check("clear_pair_cnt", 32'(if_a.pair_cnt), 32'd0);

    // Extremes
    send(0, 16'h0000, 3);
    send(0, 16'hFFFF, 3);
    wait_valid(0, "ext1_valid");
    check("ext1_hd_last", 32'(if_a.hd_last), 32'd16);
    check("ext1_hd_sum",  32'(if_a.hd_sum),  32'd16);
    send(0, 16'h1234, 3);
    send(0, 16'h1234, 3);
    wait_valid(0, "ext2_valid");
    check("ext2_hd_last",  32'(if_a.hd_last),  32'd0);
    check("ext2_hd_sum",   32'(if_a.hd_sum),   32'd16);
    check("ext2_pair_cnt", 32'(if_a.pair_cnt), 32'd2);

    // Overrun: cap at edge N+5 during COUNT is dropped
    send(0, 16'h00A2, 1);
    send(0, 16'h0091, 1);
    cyc(3);
    send(0, 16'hFFFF, 1);
    check("ovr_overrun", 32'(if_a.overrun), 32'd1);
    wait_valid(0, "ovr_pair_valid");
    check("ovr_hd_last",  32'(if_a.hd_last),  32'd4);
    check("ovr_hd_sum",   32'(if_a.hd_sum),   32'd20);
    send(0, 16'h0000, 1);
    send(0, 16'h0007, 1);
    wait_valid(0, "ovr_next_valid");
    check("ovr_next_hd_last",  32'(if_a.hd_last),  32'd3);
    check("ovr_next_hd_sum",   32'(if_a.hd_sum),   32'd23);
    check("ovr_next_pair_cnt", 32'(if_a.pair_cnt), 32'd4);
    check("ovr_sticky",        32'(if_a.overrun),  32'd1);

    // Reset at COUNT cycle 8 (edge N+8)
    send(0, 16'h00A2, 1);
    send(0, 16'h0091, 1);
    cyc(6);
    rst = 1'b1;
    cyc(1);
    check("mid_busy",     32'(if_a.busy),     32'd0);
    check("mid_hd_sum",   32'(if_a.hd_sum),   32'd0);
    check("mid_pair_cnt", 32'(if_a.pair_cnt), 32'd0);
    check("mid_overrun",  32'(if_a.overrun),  32'd0);
    check("mid_hd_last",  32'(if_a.hd_last),  32'd0);
    check("mid_hd_valid", 32'(if_a.hd_valid), 32'd0);
    check("mid_done",     32'(if_a.done),     32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seen = seen | if_a.hd_valid;
    end
    check("mid_no_valid", 32'(seen), 32'd0);
    send(0, 16'h00A2, 3);
    send(0, 16'h0091, 3);
    wait_valid(0, "post_valid");
    check("post_hd_last", 32'(if_a.hd_last), 32'd4);
    send(0, 16'h0000, 3);
    send(0, 16'hFFFF, 3);
    wait_valid(0, "post2_valid");
    check("post2_hd_sum", 32'(if_a.hd_sum), 32'd20);
`ifdef AVAL_MINMAX_EN
    check("mm_hd_min", 32'(if_a.hd_min), 32'd4);
    check("mm_hd_max", 32'(if_a.hd_max), 32'd16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
